// File: rtl/spi_reg_writer_pkg.sv
// Shared types and constants for the SPI register-write decoder.
// Frames are byte-oriented: one address byte followed by auto-incrementing data bytes.
package spi_reg_writer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } spi_state_t;

    localparam int SPI_BYTE_W = 8;
    localparam int BIT_CNT_W  = 3;

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(SPI_BYTE_W - 1);

endpackage

// File: rtl/spi_reg_writer_edge.sv
// Edge detector: registered previous value plus combinational rise/fall pulses.
// RESET_VAL chooses what the "previous" sample looks like right after reset.
module edge_detect #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic prev_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_reg <= RESET_VAL;
        end else begin
            prev_reg <= din;
        end
    end

    assign rise = din & ~prev_reg;
    assign fall = ~din & prev_reg;

endmodule

// File: rtl/spi_reg_writer.sv
// SPI mode 0, MSB-first frame decoder producing register-write strobes.
// Byte 0 of a frame sets the start address; each later byte writes and advances it.
module spi_reg_writer
    import spi_reg_writer_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = SPI_BYTE_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk_i,
    input  logic              cs_n_i,
    input  logic              mosi_i,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy
);

    spi_state_t             state_reg,   state_next;
    logic [SPI_BYTE_W-1:0]  shift_reg,   shift_next;
    logic [BIT_CNT_W-1:0]   bit_cnt_reg, bit_cnt_next;
    logic [ADDR_W-1:0]      addr_reg,    addr_next;
    logic                   wr_en_reg,   wr_en_next;
    logic [ADDR_W-1:0]      wr_addr_reg, wr_addr_next;
    logic [DATA_W-1:0]      wr_data_reg, wr_data_next;

    logic                   sclk_rise;
    logic                   sclk_fall;
    logic                   sample;
    logic                   last_bit;
    logic [SPI_BYTE_W-1:0]  byte_in;

    // Previous sclk resets high so a clock already high at reset release is not an edge.
    edge_detect #(
        .RESET_VAL (1'b1)
    ) u_sclk_edge (
        .clk   (clk),
        .reset (reset),
        .din   (sclk_i),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    assign sample   = sclk_rise & ~cs_n_i;
    assign last_bit = (bit_cnt_reg == LAST_BIT);
    assign byte_in  = {shift_reg[SPI_BYTE_W-2:0], mosi_i};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            addr_reg    <= '0;
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            addr_reg    <= addr_next;
            wr_en_reg   <= wr_en_next;
            wr_addr_reg <= wr_addr_next;
            wr_data_reg <= wr_data_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        addr_next    = addr_reg;
        wr_en_next   = 1'b0;
        wr_addr_next = wr_addr_reg;
        wr_data_next = wr_data_reg;

        if (cs_n_i) begin
            // Deselect drops any partial byte; a strobe already registered still fires.
            state_next   = IDLE;
            bit_cnt_next = '0;
        end else begin
            if (sample) begin
                shift_next   = byte_in;
                bit_cnt_next = bit_cnt_reg + 1'b1;
            end

            unique case (state_reg)
                IDLE: begin
                    state_next = ADDR;
                end
                ADDR: begin
                    if (sample && last_bit) begin
                        addr_next  = byte_in[ADDR_W-1:0];
                        state_next = DATA;
                    end
                end
                DATA: begin
                    if (sample && last_bit) begin
                        wr_en_next   = 1'b1;
                        wr_data_next = DATA_W'(byte_in);
                        wr_addr_next = addr_reg;
                        addr_next    = addr_reg + ADDR_W'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign wr_en   = wr_en_reg;
    assign wr_addr = wr_addr_reg;
    assign wr_data = wr_data_reg;
    assign busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_spi_reg_writer.sv
// Randomized self-checking bench for spi_reg_writer against a frame-level write model.
module tb_spi_reg_writer;

    logic       clk = 1'b0;
    logic       reset;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [5:0] a;
        logic [7:0] d;
    } wr_t;
    typedef logic [7:0] byte_q_t[$];

    wr_t exp_q[$];

    spi_reg_writer #(
        .ADDR_W (6),
        .DATA_W (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .sclk_i  (sclk),
        .cs_n_i  (cs_n),
        .mosi_i  (mosi),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every strobe must match the oldest outstanding modelled write.
    always @(posedge clk) begin
        #1;
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_wr", 32'(wr_en), 32'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                $display("write addr=%0d data=0x%02h (expected addr=%0d data=0x%02h)",
                         wr_addr, wr_data, e.a, e.d);
                check("wr_addr", 32'(wr_addr), 32'(e.a));
                check("wr_data", 32'(wr_data), 32'(e.d));
            end
        end
    end

    task automatic send_bit(input logic b, output logic got_wr);
        sclk = 1'b0;
        mosi = b;
        repeat (2) @(negedge clk);
        sclk = 1'b1;
        @(posedge clk);
        #1 got_wr = wr_en;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic is_data);
        logic w;
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i], w);
        end
        check("wr_strobe", 32'(w), 32'(is_data));
    endtask

    task automatic end_frame();
        sclk = 1'b0;
        repeat (2) @(negedge clk);
        cs_n = 1'b1;
        repeat (2) @(negedge clk);
        check("busy_end", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // Model: byte 0 picks a 6-bit base address; data byte k lands at base+k mod 64.
    task automatic model_frame(input byte_q_t bytes);
        logic [5:0] base;
        base = bytes[0][5:0];
        for (int i = 1; i < bytes.size(); i++) begin
            exp_q.push_back('{a: 6'((int'(base) + i - 1) % 64), d: bytes[i]});
        end
    endtask

    task automatic run_frame(input byte_q_t bytes, input int abort_bits);
        logic [7:0] pb;
        logic       w;
        $display("frame: %0d bytes, first 0x%02h, partial bits %0d",
                 bytes.size(), bytes[0], abort_bits);
        model_frame(bytes);
        cs_n = 1'b0;
        repeat (2) @(negedge clk);
        check("busy_start", 32'(busy), 32'd1);
        for (int i = 0; i < bytes.size(); i++) begin
            send_byte(bytes[i], i > 0);
        end
        pb = 8'($urandom);
        for (int k = 0; k < abort_bits; k++) begin
            send_bit(pb[7 - k], w);
        end
        end_frame();
    endtask

    initial begin
        byte_q_t fq;
        logic    w;

        reset = 1'b1;
        sclk  = 1'b0;
        cs_n  = 1'b1;
        mosi  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        fq = '{8'h05, 8'hA1, 8'hB2};
        run_frame(fq, 0);

        fq = '{8'h3F, 8'h11, 8'h22, 8'h33};
        run_frame(fq, 0);

        fq = '{8'h2A, 8'hC3};
        run_frame(fq, 4);
        fq = '{8'h01, 8'h9E};
        run_frame(fq, 0);

        // sclk activity while deselected must be invisible.
        cs_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            send_bit(1'($urandom_range(0, 1)), w);
            check("desel_busy", 32'(busy), 32'd0);
        end
        fq = '{8'h07, 8'h5C};
        run_frame(fq, 0);

        // Reset mid data byte after a completed write.
        model_frame('{8'h22, 8'h5A});
        cs_n = 1'b0;
        repeat (2) @(negedge clk);
        send_byte(8'h22, 1'b0);
        send_byte(8'h5A, 1'b1);
        for (int k = 0; k < 5; k++) begin
            send_bit(1'($urandom_range(0, 1)), w);
        end
        reset = 1'b1;
        @(negedge clk);
        check("midrst_wr_en", 32'(wr_en), 32'd0);
        check("midrst_wr_addr", 32'(wr_addr), 32'd0);
        check("midrst_wr_data", 32'(wr_data), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        sclk = 1'b0;
        cs_n = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        fq = '{8'h10, 8'h77};
        run_frame(fq, 0);

        // sclk held high and cs_n low across reset release: no phantom bit.
        reset = 1'b1;
        sclk  = 1'b1;
        cs_n  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        model_frame('{8'h2C, 8'hE4});
        send_byte(8'h2C, 1'b0);
        send_byte(8'hE4, 1'b1);
        end_frame();

        for (int f = 0; f < 10; f++) begin
            int nd;
            int ab;
            fq = {};
            fq.push_back(8'($urandom));
            nd = $urandom_range(0, 4);
            for (int i = 0; i < nd; i++) begin
                fq.push_back(8'($urandom));
            end
            ab = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 7) : 0;
            run_frame(fq, ab);
        end

        repeat (5) @(negedge clk);
        check("pending_writes", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
